runner_game_core: RTL and testbench

Parametrised game engine for the keypad/LCD runner game. Owns the run/pause/over state machine, a speed-scaled scroll tick, the obstacle track, the jump timer, collision detection, score, level and session high score. It exposes a flattened track map and dino status to the LCD text composer, and score and high score to the 7-segment controller. Inputs are single-cycle pulses from the existing keypad trigger blocks; randomness comes from the existing 16-bit LFSR.

---
 rtl/runner_pkg.sv | 14 +
 rtl/runner_tick_gen.sv | 56 +++++
 rtl/runner_game_core.sv | 189 ++++++++++++++++++
 tb/tb_runner_game_core.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/runner_pkg.sv
// Shared definitions for the runner game engine: FSM state encoding and
// the width of the speed level.
package runner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int LEVEL_W = 3;

endpackage

// File: rtl/runner_tick_gen.sv
// Scroll-tick divider. The period shrinks with the speed level down to a
// floor, and the tick is a one-cycle pulse on the cycle the divider wraps.
module runner_tick_gen
  import runner_pkg::*;
#(
  parameter int BASE_PERIOD = 250000,
  parameter int PERIOD_STEP = 25000,
  parameter int MIN_PERIOD  = 100000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear_i,
  input  logic               hold_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               tick_o
);

  localparam int DIV_W = $clog2(BASE_PERIOD + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      reduction;
  logic [31:0]      period;
  logic             wrap;

  // A level change only happens on a wrap edge, so the new period always
  // starts from a freshly cleared divider.
  always_comb begin
    reduction = 32'(level_i) * 32'(PERIOD_STEP);
    if (reduction + 32'(MIN_PERIOD) > 32'(BASE_PERIOD)) begin
      period = 32'(MIN_PERIOD);
    end else begin
      period = 32'(BASE_PERIOD) - reduction;
    end
  end

  assign wrap   = (32'(div_q) + 32'd1) >= period;
  assign tick_o = wrap && !hold_i;

  always_comb begin
    div_d = div_q;
    if (clear_i) begin
      div_d = '0;
    end else if (!hold_i) begin
      div_d = wrap ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/runner_game_core.sv
// Runner game engine: run/pause/over FSM, obstacle track, jump timer,
// collision, score, speed level and session high score.
module runner_game_core
  import runner_pkg::*;
#(
  parameter int TRACK_LEN   = 16,
  parameter int BASE_PERIOD = 250000,
  parameter int PERIOD_STEP = 25000,
  parameter int MIN_PERIOD  = 100000,
  parameter int LEVEL_SCORE = 10,
  parameter int MAX_LEVEL   = 7,
  parameter int JUMP_TICKS  = 3,
  parameter int MIN_GAP     = 2,
  parameter int SCORE_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start_p,
  input  logic                 jump_p,
  input  logic                 pause_p,
  input  logic                 abort_p,
  input  logic [15:0]          rand_in,
  output logic [1:0]           state,
  output logic [TRACK_LEN-1:0] obs_map,
  output logic                 dino_air,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   high_score,
  output logic [LEVEL_W-1:0]   level,
  output logic                 new_high
);

  localparam int AIR_W = $clog2(JUMP_TICKS + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 2);
  localparam int SUB_W = $clog2(LEVEL_SCORE + 1);

  state_t               state_q, state_d;
  logic [TRACK_LEN-1:0] map_q, map_d;
  logic [AIR_W-1:0]     air_q, air_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 new_high_q, new_high_d;
  logic                 dino_air_q;

  logic                 tick;
  logic                 clear_div;
  logic                 go_over;
  logic                 spawn;
  logic [AIR_W-1:0]     air_eff;
  logic [TRACK_LEN-1:0] shifted;
  logic                 unused_rand;

  assign unused_rand = ^rand_in[15:2];

  runner_tick_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_tick (
    .CLK     (CLK),
    .RST     (RST),
    .clear_i (clear_div),
    .hold_i  (state_q != ST_PLAY),
    .level_i (level_q),
    .tick_o  (tick)
  );

  // A jump in a tick cycle is applied before the collision check, so the
  // dino can clear an obstacle arriving on that very tick.
  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    air_d      = air_q;
    gap_d      = gap_q;
    sub_d      = sub_q;
    score_d    = score_q;
    high_d     = high_q;
    level_d    = level_q;
    new_high_d = 1'b0;
    clear_div  = 1'b0;
    go_over    = 1'b0;
    spawn      = 1'b0;
    air_eff    = air_q;
    shifted    = map_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_p) begin
          state_d   = ST_PLAY;
          map_d     = '0;
          air_d     = '0;
          gap_d     = '0;
          sub_d     = '0;
          score_d   = '0;
          level_d   = '0;
          clear_div = 1'b1;
        end
      end
      ST_PLAY: begin
        if (jump_p && air_q == '0) begin
          air_eff = AIR_W'(JUMP_TICKS);
        end
        spawn   = (rand_in[1:0] == 2'b00) && (32'(gap_q) >= 32'(MIN_GAP));
        shifted = {spawn, map_q[TRACK_LEN-1:1]};
        if (abort_p) begin
          go_over = 1'b1;
        end else begin
          air_d = air_eff;
          if (tick) begin
            map_d = shifted;
            gap_d = spawn ? '0 : ((&gap_q) ? gap_q : gap_q + GAP_W'(1));
            if (shifted[0] && air_eff == '0) begin
              go_over = 1'b1;
            end else begin
              if (air_eff != '0) begin
                air_d = air_eff - AIR_W'(1);
              end
              if (!(&score_q)) begin
                score_d = score_q + SCORE_W'(1);
                if (32'(sub_q) == LEVEL_SCORE - 1) begin
                  sub_d = '0;
                  if (32'(level_q) < 32'(MAX_LEVEL)) begin
                    level_d = level_q + LEVEL_W'(1);
                  end
                end else begin
                  sub_d = sub_q + SUB_W'(1);
                end
              end
            end
          end
          if (!go_over && pause_p) begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_p) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_over) begin
      state_d = ST_OVER;
      if (score_q > high_q) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      map_q      <= '0;
      air_q      <= '0;
      gap_q      <= '0;
      sub_q      <= '0;
      score_q    <= '0;
      high_q     <= '0;
      level_q    <= '0;
      new_high_q <= 1'b0;
      dino_air_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      air_q      <= air_d;
      gap_q      <= gap_d;
      sub_q      <= sub_d;
      score_q    <= score_d;
      high_q     <= high_d;
      level_q    <= level_d;
      new_high_q <= new_high_d;
      dino_air_q <= (air_d != '0);
    end
  end

  assign state      = state_q;
  assign obs_map    = map_q;
  assign dino_air   = dino_air_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign level      = level_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_runner_game_core.sv
// Scoreboard bench for runner_game_core: stimulus queues hand-computed
// expectations tagged with a cycle, a monitor compares them as they fall due.
module tb_runner_game_core;

  localparam int SEL_STATE = 0;
  localparam int SEL_MAP   = 1;
  localparam int SEL_AIR   = 2;
  localparam int SEL_SCORE = 3;
  localparam int SEL_HIGH  = 4;
  localparam int SEL_LEVEL = 5;
  localparam int SEL_NEWHI = 6;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_p = 1'b0;
  logic        jump_p = 1'b0;
  logic        pause_p = 1'b0;
  logic        abort_p = 1'b0;
  logic [15:0] rand_in = 16'h0000;
  logic [1:0]  state;
  logic [15:0] obs_map;
  logic        dino_air;
  logic [15:0] score;
  logic [15:0] high_score;
  logic [2:0]  level;
  logic        new_high;

  runner_game_core #(
    .TRACK_LEN   (16),
    .BASE_PERIOD (10),
    .PERIOD_STEP (2),
    .MIN_PERIOD  (6),
    .LEVEL_SCORE (4),
    .MAX_LEVEL   (7),
    .JUMP_TICKS  (3),
    .MIN_GAP     (2),
    .SCORE_W     (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_p    (start_p),
    .jump_p     (jump_p),
    .pause_p    (pause_p),
    .abort_p    (abort_p),
    .rand_in    (rand_in),
    .state      (state),
    .obs_map    (obs_map),
    .dino_air   (dino_air),
    .score      (score),
    .high_score (high_score),
    .level      (level),
    .new_high   (new_high)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    int          sel;
    logic [31:0] expVal;
    string       name;
  } exp_t;

  exp_t sbQ[$];
  int   nAssert = 0;
  int   nFail   = 0;

  function automatic logic [31:0] getActual(int sel);
    case (sel)
      SEL_STATE: return 32'(state);
      SEL_MAP:   return 32'(obs_map);
      SEL_AIR:   return 32'(dino_air);
      SEL_SCORE: return 32'(score);
      SEL_HIGH:  return 32'(high_score);
      SEL_LEVEL: return 32'(level);
      default:   return 32'(new_high);
    endcase
  endfunction

  task automatic checkOutput(input int delta, input int sel, input logic [31:0] expVal, input string name);
    exp_t e;
    e.tgt    = cyc + delta;
    e.sel    = sel;
    e.expVal = expVal;
    e.name   = name;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic s, input logic j, input logic p, input logic a);
    start_p = s;
    jump_p  = j;
    pause_p = p;
    abort_p = a;
    @(negedge CLK);
    start_p = 1'b0;
    jump_p  = 1'b0;
    pause_p = 1'b0;
    abort_p = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: just after each falling edge, retire every expectation due now.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      for (int i = sbQ.size() - 1; i >= 0; i--) begin
        if (sbQ[i].tgt == cyc) begin
          logic [31:0] act;
          act = getActual(sbQ[i].sel);
          nAssert++;
          if (act !== sbQ[i].expVal) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     sbQ[i].name, cyc, act, sbQ[i].expVal);
          end
          sbQ.delete(i);
        end
      end
    end
  end

  initial begin
    rand_in = 16'h1235;
    waitCycles(2);
    nAssert++;
    if (state !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL direct_reset_state: got %0d", state);
    end
    nAssert++;
    if (obs_map !== 16'h0000) begin
      nFail++;
      $display("[TB] FAIL direct_reset_map: got 0x%0h", obs_map);
    end
    nAssert++;
    if (score !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL direct_reset_score: got %0d", score);
    end
    nAssert++;
    if (high_score !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL direct_reset_high: got %0d", high_score);
    end
    nAssert++;
    if (level !== 3'd0) begin
      nFail++;
      $display("[TB] FAIL direct_reset_level: got %0d", level);
    end
    nAssert++;
    if (dino_air !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL direct_reset_air: got %0d", dino_air);
    end
    nAssert++;
    if (new_high !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL direct_reset_new_high: got %0d", new_high);
    end
    checkOutput(0, SEL_STATE, 0, "reset_state");
    checkOutput(0, SEL_MAP,   0, "reset_map");
    checkOutput(0, SEL_SCORE, 0, "reset_score");
    checkOutput(0, SEL_HIGH,  0, "reset_high");
    checkOutput(0, SEL_LEVEL, 0, "reset_level");
    checkOutput(0, SEL_AIR,   0, "reset_air");
    checkOutput(0, SEL_NEWHI, 0, "reset_new_high");
    RST = 1'b0;
    waitCycles(2);

    // Game 1: no obstacles, tick spacing 10,10,10,10,8x4,6x4,6...
    applyStimulus(1, 0, 0, 0);
    checkOutput(0,   SEL_STATE, 1,  "start_state");
    checkOutput(0,   SEL_SCORE, 0,  "start_score");
    checkOutput(9,   SEL_SCORE, 0,  "tick1_not_yet");
    checkOutput(10,  SEL_SCORE, 1,  "tick1_score");
    checkOutput(10,  SEL_MAP,   0,  "tick1_map_empty");
    checkOutput(39,  SEL_LEVEL, 0,  "level0_before_4pts");
    checkOutput(40,  SEL_LEVEL, 1,  "level1_at_4pts");
    checkOutput(47,  SEL_SCORE, 4,  "lvl1_spacing_early");
    checkOutput(48,  SEL_SCORE, 5,  "lvl1_spacing_8");
    checkOutput(72,  SEL_LEVEL, 2,  "level2");
    checkOutput(77,  SEL_SCORE, 8,  "lvl2_spacing_early");
    checkOutput(78,  SEL_SCORE, 9,  "lvl2_spacing_6");
    checkOutput(96,  SEL_LEVEL, 3,  "level3");
    checkOutput(101, SEL_SCORE, 12, "lvl3_spacing_early");
    checkOutput(102, SEL_SCORE, 13, "lvl3_spacing_min");
    waitCycles(103);
    applyStimulus(0, 0, 0, 1);
    checkOutput(0, SEL_STATE, 3,  "abort_state");
    checkOutput(0, SEL_SCORE, 13, "abort_score");
    checkOutput(0, SEL_HIGH,  13, "abort_high");
    checkOutput(0, SEL_NEWHI, 1,  "abort_new_high");
    checkOutput(1, SEL_NEWHI, 0,  "abort_new_high_one_cycle");
    waitCycles(2);

    // Game 2: spawn every 3rd tick, first obstacle hits the grounded dino at tick 18
    rand_in = 16'hAB0C;
    applyStimulus(1, 0, 0, 0);
    checkOutput(0,   SEL_HIGH,  13,       "high_kept_on_start");
    checkOutput(0,   SEL_SCORE, 0,        "restart_score");
    checkOutput(0,   SEL_LEVEL, 0,        "restart_level");
    checkOutput(20,  SEL_MAP,   0,        "no_spawn_before_gap");
    checkOutput(30,  SEL_MAP,   16'h8000, "spawn_tick3");
    checkOutput(40,  SEL_MAP,   16'h4000, "shift_tick4");
    checkOutput(126, SEL_MAP,   16'h2492, "map_tick17");
    checkOutput(126, SEL_SCORE, 17,       "score_tick17");
    checkOutput(126, SEL_LEVEL, 4,        "level4");
    checkOutput(132, SEL_STATE, 3,        "collision_state");
    checkOutput(132, SEL_SCORE, 17,       "collision_score_held");
    checkOutput(132, SEL_MAP,   16'h9249, "collision_map");
    checkOutput(132, SEL_HIGH,  17,       "collision_high");
    checkOutput(132, SEL_NEWHI, 1,        "collision_new_high");
    checkOutput(133, SEL_NEWHI, 0,        "collision_new_high_end");
    waitCycles(134);

    // Game 3: jump on the tick that brings the obstacle to cell 0
    applyStimulus(1, 0, 0, 0);
    checkOutput(131, SEL_AIR,   0,        "grounded_before_jump");
    checkOutput(132, SEL_STATE, 1,        "jump_clears_obstacle");
    checkOutput(132, SEL_SCORE, 18,       "jump_tick_score");
    checkOutput(132, SEL_MAP,   16'h9249, "jump_tick_map");
    checkOutput(132, SEL_AIR,   1,        "air_after_jump");
    checkOutput(135, SEL_AIR,   1,        "air_after_second_jump");
    checkOutput(138, SEL_AIR,   1,        "air_tick19");
    checkOutput(138, SEL_SCORE, 19,       "score_tick19");
    checkOutput(144, SEL_AIR,   0,        "air_ends_tick20");
    checkOutput(144, SEL_SCORE, 20,       "score_tick20");
    checkOutput(150, SEL_STATE, 3,        "landed_collision");
    checkOutput(150, SEL_SCORE, 20,       "landed_score");
    checkOutput(150, SEL_HIGH,  20,       "landed_high");
    checkOutput(150, SEL_NEWHI, 1,        "landed_new_high");
    waitCycles(131);
    applyStimulus(0, 1, 0, 0);
    waitCycles(2);
    applyStimulus(0, 1, 0, 0);
    waitCycles(16);

    // Game 4: pause mid-count, resume, then abort with a lower score
    rand_in = 16'h1235;
    applyStimulus(1, 0, 0, 0);
    checkOutput(10, SEL_SCORE, 1, "pause_game_tick1");
    checkOutput(15, SEL_STATE, 2, "paused_state");
    checkOutput(40, SEL_SCORE, 1, "paused_score_hold");
    checkOutput(64, SEL_STATE, 2, "paused_state_late");
    checkOutput(64, SEL_SCORE, 1, "paused_score_late");
    checkOutput(64, SEL_MAP,   0, "paused_map");
    checkOutput(65, SEL_STATE, 1, "resumed_state");
    checkOutput(69, SEL_SCORE, 1, "resume_remaining_early");
    checkOutput(70, SEL_SCORE, 2, "resume_remaining_tick");
    waitCycles(14);
    applyStimulus(0, 0, 1, 0);
    waitCycles(49);
    applyStimulus(0, 0, 1, 0);
    waitCycles(6);
    applyStimulus(0, 0, 0, 1);
    checkOutput(0, SEL_STATE, 3,  "lower_abort_state");
    checkOutput(0, SEL_SCORE, 2,  "lower_abort_score");
    checkOutput(0, SEL_HIGH,  20, "high_kept_lower_score");
    checkOutput(0, SEL_NEWHI, 0,  "no_new_high_lower");
    waitCycles(2);

    // Game 5: abort, jump and tick on the same edge
    applyStimulus(1, 0, 0, 0);
    checkOutput(9,  SEL_STATE, 1,  "pre_abort_play");
    checkOutput(10, SEL_STATE, 3,  "abort_beats_tick_state");
    checkOutput(10, SEL_SCORE, 0,  "abort_beats_tick_score");
    checkOutput(10, SEL_AIR,   0,  "abort_beats_jump");
    checkOutput(10, SEL_NEWHI, 0,  "abort_zero_no_new_high");
    checkOutput(10, SEL_HIGH,  20, "abort_zero_high");
    waitCycles(9);
    applyStimulus(0, 1, 0, 1);
    waitCycles(2);

    // Game 6: asynchronous reset in the middle of play
    rand_in = 16'hAB0C;
    applyStimulus(1, 0, 0, 0);
    checkOutput(31, SEL_MAP,   16'h8000, "pre_reset_map");
    checkOutput(31, SEL_SCORE, 3,        "pre_reset_score");
    checkOutput(31, SEL_HIGH,  20,       "pre_reset_high");
    waitCycles(31);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    checkOutput(0, SEL_STATE, 0, "async_reset_state");
    checkOutput(0, SEL_MAP,   0, "async_reset_map");
    checkOutput(0, SEL_SCORE, 0, "async_reset_score");
    checkOutput(0, SEL_HIGH,  0, "async_reset_high");
    checkOutput(0, SEL_LEVEL, 0, "async_reset_level");
    checkOutput(0, SEL_AIR,   0, "async_reset_air");
    waitCycles(2);
    RST = 1'b0;
    waitCycles(3);

    foreach (sbQ[i]) begin
      nAssert++;
      nFail++;
      $display("[TB] FAIL %s never checked: due cycle %0d, expected 0x%0h",
               sbQ[i].name, sbQ[i].tgt, sbQ[i].expVal);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
